bus_debug_master: RTL
=====================

// Module: bus_debug_master
// PURPOSE
//  Byte-stream-to-memory-bus initiator: the other end of the SoC common memory bus.
//  Decodes command bytes from a byte source (UART rx path), drives one read/write on
//  the bus and returns status/data bytes on a byte sink (UART tx path).
//  Sits beside rv32 as a second bus initiator; used for debug, loading and bring-up.
// PARAMETERS
//  TIMEOUT_CYCLES  1024  max cycles a request is held without ready_in (0 = no timeout)
// PORTS
//  clk              in   1   system clock (pll_clk domain); single clock
//  reset_n          in   1   asynchronous, active-low reset
//  rx_data_in       in   8   command byte
//  rx_valid_in      in   1   rx_data_in valid
//  rx_ready_out     out  1   block accepts rx byte this cycle
//  tx_data_out      out  8   response byte
//  tx_valid_out     out  1   tx_data_out valid
//  tx_ready_in      in   1   sink accepts tx byte this cycle
//  address_out      out  32  bus address
//  read_out         out  1   bus read request
//  write_out        out  1   bus write request
//  write_mask_out   out  4   byte-lane write mask (0 during reads)
//  write_value_out  out  32  bus write data
//  read_value_in    in   32  bus read data, valid when ready_in
//  ready_in         in   1   bus completion (may be same cycle as request)
//  fault_in         in   1   bus fault, qualified by ready_in
//  busy_out         out  1   high in any state except IDLE
// BEHAVIOUR
//  Reset (async, reset_n low): state IDLE; every output 0; counters cleared.
//  Byte transfer: rx when rx_valid_in & rx_ready_out; tx when tx_valid_out & tx_ready_in.
//  rx_ready_out = 1 only in IDLE, ADDR, DATA. tx_data_out held stable while tx_valid_out=1.
//  Command byte: [7:4] opcode (1 = read, 2 = write), [3:0] write mask.
//  Frame: cmd, 4 addr bytes LSB first, then (write only) 4 data bytes LSB first.
//  States:
//   IDLE: accept cmd. op=1 -> ADDR. op=2 & mask!=0 -> ADDR. else status=0x03 -> RESP_STATUS.
//   ADDR: shift 4 bytes into address (byte n -> bits 8n+7:8n); after 4th: read -> BUS,
//         write -> DATA.
//   DATA: same for write_value; after 4th -> BUS.
//   BUS: read_out/write_out high, address/mask/value stable, timeout counter runs.
//        ready_in=1: capture read_value_in, status = fault_in ? 0x01 : 0x00, drop request
//        next cycle -> RESP_STATUS. Minimum 1 cycle in BUS.
//        Counter reaches TIMEOUT_CYCLES without ready_in: drop request, status 0x02.
//        ready_in on the final timeout cycle: ready wins (status 0x00/0x01).
//   RESP_STATUS: present status; on transfer: read with status 0x00 -> RESP_DATA,
//        else -> IDLE.
//   RESP_DATA: present captured read data, 4 bytes LSB first; after 4th -> IDLE.
//  read_out and write_out never both high; write_mask_out=0 whenever write_out=0.
//  Faulted/timed-out reads return status byte only (no data bytes).
//  Byte counter 2 bits, wraps 3->0 at end of each field.
//  rx bytes presented while not in IDLE/ADDR/DATA are not consumed (rx_ready_out=0).
//  reset_n low mid-transaction: request dropped immediately, partial frame discarded.
// TESTING
//  1 rx 2F 00 00 01 00 AA 00 00 00, ready_in same cycle -> one write cycle
//    addr 0x00010000, mask F, value 0x000000AA; tx 00.
//  2 rx 10 00 00 01 00, ready_in after 3 cycles with read_value 0x000000AA -> read_out
//    held 3 cycles, write_mask_out=0; tx 00 AA 00 00 00.
//  3 rx 10 00 00 00 20 (addr 0x20000000), ready_in=fault_in=1 -> tx 01 only; IDLE.
//  4 TIMEOUT_CYCLES=8, read with ready_in never high -> read_out high 8 cycles, tx 02;
//    repeat with ready_in on 8th cycle -> tx 00 + data.
//  5 rx 30, then rx 20 -> tx 03 each time (bad opcode, zero mask); next byte is new cmd.
//  6 tx_ready_in low 5 cycles during read response -> bytes held, none lost/duplicated;
//    reset_n pulsed during BUS -> outputs 0 at once, next frame handled normally.

Source files
------------

// File: rtl/bus_debug_master_if.sv
// Byte-stream and memory-bus signal bundle for the debug bus initiator.
// Latency: none (wires only).
// Backpressure: rx/tx use valid/ready; the bus side uses request/ready_in completion.
interface bus_debug_master_if;
  // command byte source
  logic [7:0]  rx_data_in;
  logic        rx_valid_in;
  logic        rx_ready_out;
  // response byte sink
  logic [7:0]  tx_data_out;
  logic        tx_valid_out;
  logic        tx_ready_in;
  // memory bus initiator side
  logic [31:0] address_out;
  logic        read_out;
  logic        write_out;
  logic [3:0]  write_mask_out;
  logic [31:0] write_value_out;
  logic [31:0] read_value_in;
  logic        ready_in;
  logic        fault_in;
  // status
  logic        busy_out;

  // the debug master itself
  modport master (
    input  rx_data_in, rx_valid_in,
    output rx_ready_out,
    output tx_data_out, tx_valid_out,
    input  tx_ready_in,
    output address_out, read_out, write_out, write_mask_out, write_value_out,
    input  read_value_in, ready_in, fault_in,
    output busy_out
  );

  // the environment: byte source/sink and bus target
  modport slave (
    output rx_data_in, rx_valid_in,
    input  rx_ready_out,
    input  tx_data_out, tx_valid_out,
    output tx_ready_in,
    input  address_out, read_out, write_out, write_mask_out, write_value_out,
    output read_value_in, ready_in, fault_in,
    input  busy_out
  );
endinterface

// File: rtl/bus_debug_master.sv
// Byte-stream command decoder driving one read/write on the memory bus, returning status/data bytes.
// Latency: bus request the cycle after the last frame byte; status byte the cycle after bus completion.
// Backpressure: rx accepted only while collecting a frame; tx bytes held until tx_ready_in.
module bus_debug_master #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic               clk,
  input logic               reset_n,
  bus_debug_master_if.master dbg
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP_STATUS,
    ST_RESP_DATA
  } state_t;

  localparam logic [7:0] STAT_OK      = 8'h00;
  localparam logic [7:0] STAT_FAULT   = 8'h01;
  localparam logic [7:0] STAT_TIMEOUT = 8'h02;
  localparam logic [7:0] STAT_BADCMD  = 8'h03;

  // Counter only has to reach TIMEOUT_CYCLES-1; the terminal cycle is detected by compare.
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          is_wr_q, is_wr_d;
  logic [3:0]    mask_q, mask_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [7:0]    status_q, status_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic       rx_fire;
  logic       tx_fire;
  logic [3:0] cmd_op;
  logic [3:0] cmd_mask;
  logic       cmd_ok;
  logic       tmo_hit;

  assign rx_fire  = dbg.rx_valid_in & dbg.rx_ready_out;
  assign tx_fire  = dbg.tx_valid_out & dbg.tx_ready_in;
  assign cmd_op   = dbg.rx_data_in[7:4];
  assign cmd_mask = dbg.rx_data_in[3:0];
  // A write with an empty mask would be a no-op bus cycle, so it is rejected like a bad opcode.
  assign cmd_ok   = (cmd_op == 4'd1) || ((cmd_op == 4'd2) && (cmd_mask != 4'd0));
  // TIMEOUT_CYCLES of zero disables the timeout entirely.
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_q == TMO_LAST);

  // State and datapath registers; reset discards any partial frame and drops the request.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 2'd0;
      is_wr_q  <= 1'b0;
      mask_q   <= 4'd0;
      addr_q   <= 32'd0;
      wdata_q  <= 32'd0;
      rdata_q  <= 32'd0;
      status_q <= 8'd0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_wr_q  <= is_wr_d;
      mask_q   <= mask_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      tmo_q    <= tmo_d;
    end
  end

  // Next-state: frame collection, one bus cycle, then status (and read data) response.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_fire) state_d = cmd_ok ? ST_ADDR : ST_RESP_STATUS;
      end
      ST_ADDR: begin
        if (rx_fire && (cnt_q == 2'd3)) state_d = is_wr_q ? ST_DATA : ST_BUS;
      end
      ST_DATA: begin
        if (rx_fire && (cnt_q == 2'd3)) state_d = ST_BUS;
      end
      ST_BUS: begin
        // ready_in on the terminal timeout cycle still counts as a completion.
        if (dbg.ready_in || tmo_hit) state_d = ST_RESP_STATUS;
      end
      ST_RESP_STATUS: begin
        if (tx_fire) state_d = (!is_wr_q && (status_q == STAT_OK)) ? ST_RESP_DATA : ST_IDLE;
      end
      ST_RESP_DATA: begin
        if (tx_fire && (cnt_q == 2'd3)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: byte shifting, bus completion capture, timeout counting.
  always_comb begin
    cnt_d    = cnt_q;
    is_wr_d  = is_wr_q;
    mask_d   = mask_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    tmo_d    = tmo_q;
    unique case (state_q)
      ST_IDLE: begin
        if (rx_fire) begin
          cnt_d   = 2'd0;
          is_wr_d = (cmd_op == 4'd2);
          mask_d  = (cmd_op == 4'd2) ? cmd_mask : 4'd0;
          tmo_d   = '0;
          if (!cmd_ok) status_d = STAT_BADCMD;
        end
      end
      ST_ADDR: begin
        if (rx_fire) begin
          addr_d[{cnt_q, 3'b000} +: 8] = dbg.rx_data_in;
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_DATA: begin
        if (rx_fire) begin
          wdata_d[{cnt_q, 3'b000} +: 8] = dbg.rx_data_in;
          cnt_d = cnt_q + 2'd1;
        end
      end
      ST_BUS: begin
        tmo_d = tmo_q + TW'(1);
        if (dbg.ready_in) begin
          rdata_d  = dbg.read_value_in;
          status_d = dbg.fault_in ? STAT_FAULT : STAT_OK;
          tmo_d    = '0;
        end else if (tmo_hit) begin
          status_d = STAT_TIMEOUT;
          tmo_d    = '0;
        end
      end
      ST_RESP_STATUS: begin
        if (tx_fire) cnt_d = 2'd0;
      end
      ST_RESP_DATA: begin
        if (tx_fire) cnt_d = cnt_q + 2'd1;
      end
      default: begin
        cnt_d = 2'd0;
      end
    endcase
  end

  // Outputs decoded from state; rx_ready is forced low while reset is asserted.
  always_comb begin
    dbg.rx_ready_out    = 1'b0;
    dbg.tx_valid_out    = 1'b0;
    dbg.tx_data_out     = 8'd0;
    dbg.read_out        = 1'b0;
    dbg.write_out       = 1'b0;
    dbg.write_mask_out  = 4'd0;
    dbg.address_out     = addr_q;
    dbg.write_value_out = wdata_q;
    dbg.busy_out        = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE, ST_ADDR, ST_DATA: begin
        dbg.rx_ready_out = reset_n;
      end
      ST_BUS: begin
        dbg.read_out       = !is_wr_q;
        dbg.write_out      = is_wr_q;
        dbg.write_mask_out = is_wr_q ? mask_q : 4'd0;
      end
      ST_RESP_STATUS: begin
        dbg.tx_valid_out = 1'b1;
        dbg.tx_data_out  = status_q;
      end
      ST_RESP_DATA: begin
        dbg.tx_valid_out = 1'b1;
        dbg.tx_data_out  = rdata_q[{cnt_q, 3'b000} +: 8];
      end
      default: begin
        dbg.rx_ready_out = 1'b0;
      end
    endcase
  end

endmodule
